// File: rtl/keyboard_pkg.sv
// Shared scan-code constants, FSM state types and the parity helper for the
// PS/2 keyboard controller.
package keyboard_pkg;

    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        DEC_IDLE,
        DEC_EXT,
        DEC_BRK,
        DEC_EXT_BRK
    } dec_state_e;

    // Odd parity: the data bits plus the parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: input synchronizers, falling-edge detect, 11-bit frame
// FSM and an inter-bit timeout that abandons stalled frames.
module ps2_rx
    import keyboard_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 65_000_000,
    parameter int unsigned TIMEOUT_US = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam longint unsigned TIMEOUT_CYC =
        (longint'(TIMEOUT_US) * longint'(CLK_HZ)) / 64'd1_000_000;
    localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    // [0],[1] synchronize ps2_clk; [2] is the delayed copy for edge detection.
    logic [2:0]       clk_sync_q;
    logic [1:0]       data_sync_q;
    rx_state_e        state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [7:0]       byte_q, byte_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             fall;
    logic             data_s;

    assign fall   = clk_sync_q[2] & ~clk_sync_q[1];
    assign data_s = data_sync_q[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            state_q     <= RX_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tmo_cnt_q   <= '0;
            byte_q      <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tmo_cnt_q   <= tmo_cnt_d;
            byte_q      <= byte_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tmo_cnt_d = '0;
        byte_d    = byte_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        // Gap counter only runs mid-frame and restarts on every edge.
        if (state_q != RX_IDLE && !fall) begin
            if (tmo_cnt_q == TMO_LAST) begin
                state_d = RX_IDLE;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end

        if (fall) begin
            case (state_q)
                RX_IDLE: begin
                    if (!data_s) begin
                        state_d   = RX_DATA;
                        bit_cnt_d = '0;
                    end
                end
                RX_DATA: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = RX_PARITY;
                    end
                end
                RX_PARITY: begin
                    par_d   = data_s;
                    state_d = RX_STOP;
                end
                RX_STOP: begin
                    state_d = RX_IDLE;
                    if (data_s && odd_parity_ok(shift_q, par_q)) begin
                        valid_d = 1'b1;
                        byte_d  = shift_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    assign rx_byte  = byte_q;
    assign rx_valid = valid_q;
    assign rx_err   = err_q;

endmodule

// File: rtl/keyboard_ctl.sv
// PS/2 keyboard controller: decodes make/break (and E0-extended) scan codes
// into held-key levels for space, left arrow and right arrow.
module keyboard_ctl
    import keyboard_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 65_000_000,
    parameter int unsigned TIMEOUT_US = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_space,
    output logic       key_left,
    output logic       key_right,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);

    dec_state_e dec_state_q, dec_state_d;
    logic       space_q, space_d;
    logic       left_q, left_d;
    logic       right_q, right_d;

    ps2_rx #(
        .CLK_HZ     (CLK_HZ),
        .TIMEOUT_US (TIMEOUT_US)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_err   (rx_err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dec_state_q <= DEC_IDLE;
            space_q     <= 1'b0;
            left_q      <= 1'b0;
            right_q     <= 1'b0;
        end else begin
            dec_state_q <= dec_state_d;
            space_q     <= space_d;
            left_q      <= left_d;
            right_q     <= right_d;
        end
    end

    always_comb begin
        dec_state_d = dec_state_q;
        space_d     = space_q;
        left_d      = left_q;
        right_d     = right_q;

        if (rx_err) begin
            dec_state_d = DEC_IDLE;
        end else if (rx_valid) begin
            case (rx_byte)
                SC_EXT: begin
                    // E0 after a plain F0 starts a fresh extended sequence.
                    if (dec_state_q != DEC_EXT_BRK) begin
                        dec_state_d = DEC_EXT;
                    end
                end
                SC_BRK: begin
                    if (dec_state_q == DEC_EXT || dec_state_q == DEC_EXT_BRK) begin
                        dec_state_d = DEC_EXT_BRK;
                    end else begin
                        dec_state_d = DEC_BRK;
                    end
                end
                default: begin
                    dec_state_d = DEC_IDLE;
                    case (dec_state_q)
                        DEC_IDLE: if (rx_byte == SC_SPACE) space_d = 1'b1;
                        DEC_BRK:  if (rx_byte == SC_SPACE) space_d = 1'b0;
                        DEC_EXT: begin
                            if (rx_byte == SC_LEFT)  left_d  = 1'b1;
                            if (rx_byte == SC_RIGHT) right_d = 1'b1;
                        end
                        DEC_EXT_BRK: begin
                            if (rx_byte == SC_LEFT)  left_d  = 1'b0;
                            if (rx_byte == SC_RIGHT) right_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end

    assign key_space = space_q;
    assign key_left  = left_q;
    assign key_right = right_q;

endmodule

// File: tb/tb_keyboard_ctl.sv
// Directed bench for keyboard_ctl: bit-level PS/2 keyboard driver, frame and
// key-state model checked every cycle, plus literal spot checks per scenario.
module tb_keyboard_ctl;
    import keyboard_pkg::*;

    // 1 time unit = 1 ns; system clock 1 MHz so one cycle = 1 us.
    localparam int HALF_CLK = 500;
    localparam int US       = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       key_space, key_left, key_right;
    logic [7:0] rx_byte;
    logic       rx_valid, rx_err;

    keyboard_ctl #(
        .CLK_HZ     (1_000_000),
        .TIMEOUT_US (200)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key_space (key_space),
        .key_left  (key_left),
        .key_right (key_right),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .rx_err    (rx_err)
    );

    always #HALF_CLK clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [7:0] b;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   valid_seen = 0;
    int   err_seen = 0;

    // Model state: prefix flags and held keys.
    bit         m_ext, m_brk, m_space, m_left, m_right;
    logic [7:0] m_byte;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE0) begin
            if (!(m_ext && m_brk)) begin
                m_ext = 1'b1;
                m_brk = 1'b0;
            end
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (!m_ext && b == 8'h29) m_space = !m_brk;
            if (m_ext && b == 8'h6B)  m_left  = !m_brk;
            if (m_ext && b == 8'h74)  m_right = !m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
                m_ext = 0; m_brk = 0; m_space = 0; m_left = 0; m_right = 0;
                m_byte = 8'h00;
                check("reset_outputs",
                      32'({key_space, key_left, key_right, rx_valid, rx_err, rx_byte}), 32'd0);
            end else begin
                check("keys", 32'({key_space, key_left, key_right}),
                      32'({m_space, m_left, m_right}));
                if (rx_valid || rx_err) begin
                    check("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("pulse_kind", 32'(rx_err), 32'(e.is_err));
                        if (e.is_err) begin
                            m_ext = 1'b0;
                            m_brk = 1'b0;
                        end else begin
                            m_byte = e.b;
                            model_byte(e.b);
                        end
                    end
                    if (rx_valid) valid_seen++;
                    if (rx_err) err_seen++;
                end
                check("rx_byte", 32'(rx_byte), 32'(m_byte));
            end
        end
    end

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        #(20 * US);
        ps2_clk = 1'b0;
        #(40 * US);
        ps2_clk = 1'b1;
        #(20 * US);
    endtask

    // Drive the first nbits of a frame (start, data LSB first, parity, stop).
    task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] fr;
        logic        p;
        p  = bad_par ? ^b : ~^b;
        fr = {1'b1, p, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(fr[i]);
        ps2_data = 1'b1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        check("frame_drain", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        exp_t e;
        e.is_err = bad_par;
        e.b      = b;
        exp_q.push_back(e);
        $display("frame byte=%02h bad_parity=%0d", b, bad_par);
        send_bits(b, bad_par, 11);
        wait_drain();
    endtask

    initial begin
        int v0, e0;
        #(5 * US + 300);
        check("reset_dec_idle", 32'(dut.dec_state_q), 32'(DEC_IDLE));
        check("reset_rx_idle", 32'(dut.u_rx.state_q), 32'(RX_IDLE));
        check("reset_tmo_zero", 32'(dut.u_rx.tmo_cnt_q), 32'd0);
        rst = 1'b1;
        #(10 * US);

        // Space make then break.
        send_frame(8'h29, 0);
        check("space_make", 32'(key_space), 32'd1);
        check("space_rx_byte", 32'(rx_byte), 32'h29);
        send_frame(8'hF0, 0);
        send_frame(8'h29, 0);
        check("space_break", 32'(key_space), 32'd0);

        // Extended left make/break, then plain 6B ignored.
        send_frame(8'hE0, 0);
        send_frame(8'h6B, 0);
        check("left_make", 32'(key_left), 32'd1);
        send_frame(8'hE0, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h6B, 0);
        check("left_break", 32'(key_left), 32'd0);
        send_frame(8'h6B, 0);
        check("plain_6b_keys", 32'({key_space, key_left, key_right}), 32'd0);
        check("plain_6b_dec_idle", 32'(dut.dec_state_q), 32'(DEC_IDLE));

        // Bad parity, then a good frame.
        e0 = err_seen;
        send_frame(8'h29, 1);
        check("parity_err_pulse", 32'(err_seen - e0), 32'd1);
        check("parity_err_space", 32'(key_space), 32'd0);
        send_frame(8'h29, 0);
        check("after_err_space", 32'(key_space), 32'd1);

        // Truncated frame times out silently.
        v0 = valid_seen;
        e0 = err_seen;
        $display("partial frame byte=29 bits=4");
        send_bits(8'h29, 0, 4);
        #(300 * US);
        check("timeout_rx_idle", 32'(dut.u_rx.state_q), 32'(RX_IDLE));
        check("timeout_no_valid", 32'(valid_seen - v0), 32'd0);
        check("timeout_no_err", 32'(err_seen - e0), 32'd0);
        send_frame(8'h29, 0);
        check("timeout_next_byte", 32'(rx_byte), 32'h29);
        check("timeout_next_space", 32'(key_space), 32'd1);
        send_frame(8'hF0, 0);
        send_frame(8'h29, 0);

        // Simultaneous left and right.
        send_frame(8'hE0, 0);
        send_frame(8'h6B, 0);
        send_frame(8'hE0, 0);
        send_frame(8'h74, 0);
        check("both_held", 32'({key_left, key_right}), 32'b11);
        send_frame(8'hE0, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h6B, 0);
        check("left_rel_right_held", 32'({key_left, key_right}), 32'b01);

        // Reset mid-frame while right is held.
        $display("partial frame byte=e0 bits=5 then reset");
        send_bits(8'hE0, 0, 5);
        #300;
        rst = 1'b0;
        #1;
        check("async_reset_outputs",
              32'({key_space, key_left, key_right, rx_valid, rx_err, rx_byte}), 32'd0);
        #(3 * US);
        rst = 1'b1;
        #(10 * US);
        check("post_reset_rx_idle", 32'(dut.u_rx.state_q), 32'(RX_IDLE));
        send_frame(8'hE0, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h74, 0);
        check("right_break_unheld", 32'(key_right), 32'd0);
        check("final_rx_byte", 32'(rx_byte), 32'h74);

        #(10 * US);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #(100_000 * US);
        $display("FAIL watchdog: simulation time limit reached, passes %0d checks %0d", passes, checks);
        $fatal(1, "watchdog");
    end

endmodule
